// File: rtl/decode_stage_cp4_if.sv
// Fetch-to-decode bus for decode_stage_cp4.
// The master side is the fetch unit plus pipeline control (stall/flush);
// the slave side is the IF/ID stage, which returns the decoded view.
interface decode_stage_cp4_if;
    // Fetch handshake
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_ready;

    // Pipeline control
    logic        stall;
    logic        flush;

    // Presented instruction and decode fields
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  id_imm_type;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, stall, flush,
        input  fetch_ready, id_valid, id_pc, id_inst,
               id_imm_type, id_rd, id_rs1, id_rs2
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, stall, flush,
        output fetch_ready, id_valid, id_pc, id_inst,
               id_imm_type, id_rd, id_rs1, id_rs2
    );
endinterface

// File: rtl/decode_stage_cp4.sv
// IF/ID pipeline register with a two-entry skid buffer and opcode decoder
// for the CP4 core. Main entry M is always what decode sees; skid entry S
// catches a fetch that was already in flight when decode stalled.
//
// Optional feature: define DECODE_CSR_IMM_EN to decode the CSR-immediate
// SYSTEM forms (funct3[2]=1) to immediate selector 3'b101. Without it every
// SYSTEM instruction maps to 3'b111 (zero immediate).
module decode_stage_cp4 #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    decode_stage_cp4_if.slave  bus
);

    // Occupancy of the buffer; the encoding mirrors {S.valid, M.valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } buf_state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_CSR  = 3'b101;
    localparam logic [2:0] IMM_NONE = 3'b111;

    buf_state_t  state_reg;
    logic [31:0] m_pc_reg;
    logic [31:0] m_inst_reg;
    logic [31:0] s_pc_reg;
    logic [31:0] s_inst_reg;
    logic        fetch_ready_reg;
    logic        id_valid_reg;

    logic        accept;
    logic [31:0] id_inst_w;
    logic [2:0]  imm_type_next;

    // A fetch only counts when the buffer has room and no redirect is pending.
    assign accept = bus.fetch_valid && fetch_ready_reg && !bus.flush;

    // Buffer state machine; fetch_ready and id_valid are registered alongside
    // the occupancy so neither stall nor flush reaches them combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= EMPTY;
            m_pc_reg        <= RESET_PC;
            m_inst_reg      <= NOP_INST;
            s_pc_reg        <= '0;
            s_inst_reg      <= '0;
            fetch_ready_reg <= 1'b1;
            id_valid_reg    <= 1'b0;
        end else if (bus.flush) begin
            // Redirect wins over stall and drops any same-cycle fetch.
            // m_pc_reg is kept so id_pc still shows the last held PC.
            state_reg       <= EMPTY;
            fetch_ready_reg <= 1'b1;
            id_valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    // An empty stage takes the fetch into M whether or not
                    // decode is stalled.
                    if (accept) begin
                        m_pc_reg     <= bus.fetch_pc;
                        m_inst_reg   <= bus.fetch_inst;
                        state_reg    <= ONE;
                        id_valid_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (!bus.stall) begin
                        if (accept) begin
                            m_pc_reg   <= bus.fetch_pc;
                            m_inst_reg <= bus.fetch_inst;
                        end else begin
                            state_reg    <= EMPTY;
                            id_valid_reg <= 1'b0;
                        end
                    end else if (accept) begin
                        // M is held, so the in-flight fetch parks in S.
                        s_pc_reg        <= bus.fetch_pc;
                        s_inst_reg      <= bus.fetch_inst;
                        state_reg       <= FULL;
                        fetch_ready_reg <= 1'b0;
                    end
                end
                FULL: begin
                    // fetch_ready is low here, so no accept can occur; on
                    // release the skid entry moves forward into M.
                    if (!bus.stall) begin
                        m_pc_reg        <= s_pc_reg;
                        m_inst_reg      <= s_inst_reg;
                        state_reg       <= ONE;
                        fetch_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg       <= EMPTY;
                    fetch_ready_reg <= 1'b1;
                    id_valid_reg    <= 1'b0;
                end
            endcase
        end
    end

    // A bubble is presented as the canonical NOP so all fields decode to zero.
    assign id_inst_w = id_valid_reg ? m_inst_reg : NOP_INST;

    // Immediate selector for immediate_generator_cp4, keyed on the opcode.
    always_comb begin
        imm_type_next = IMM_NONE;
        case (id_inst_w[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm_type_next = IMM_I;
            OP_STORE:                 imm_type_next = IMM_S;
            OP_BRANCH:                imm_type_next = IMM_B;
            OP_LUI, OP_AUIPC:         imm_type_next = IMM_U;
            OP_JAL:                   imm_type_next = IMM_J;
`ifdef DECODE_CSR_IMM_EN
            OP_SYSTEM:                imm_type_next = id_inst_w[14] ? IMM_CSR : IMM_NONE;
`else
            OP_SYSTEM:                imm_type_next = IMM_NONE;
`endif
            default:                  imm_type_next = IMM_NONE;
        endcase
    end

    assign bus.fetch_ready = fetch_ready_reg;
    assign bus.id_valid    = id_valid_reg;
    assign bus.id_pc       = m_pc_reg;
    assign bus.id_inst     = id_inst_w;
    assign bus.id_imm_type = imm_type_next;
    assign bus.id_rd       = id_inst_w[11:7];
    assign bus.id_rs1      = id_inst_w[19:15];
    assign bus.id_rs2      = id_inst_w[24:20];

endmodule
